// File: rtl/mv_avg_filter_8.sv
// 8-tap moving-average filter on 14-bit signed samples, decimated by a
// programmable prescaler strobe; output is floor(sum/8) registered one edge late.
module mv_avg_filter_8 (
  input  logic               clk,
  input  logic               rst,
  input  logic        [31:0] i32_prescaler,
  input  logic signed [13:0] is14_data,
  output logic signed [13:0] os14_data
);
  localparam int NTAPS = 8;
  localparam int DW    = 14;
  localparam int SW    = 17;

  logic        [31:0]              cnt_q, cnt_d, p_last;
  logic                            strobe;
  logic [NTAPS-1:0][DW-1:0]        taps_q, taps_d;
  logic signed [SW-1:0]            sum_q, sum_d;
  logic signed [DW-1:0]            out_q, out_d;

  always_comb begin
    // P = 0 behaves as P = 1; '>=' keeps a shrinking prescaler from locking up
    p_last = (i32_prescaler == 32'd0) ? 32'd0 : i32_prescaler - 32'd1;
    strobe = (cnt_q >= p_last);
    cnt_d  = strobe ? 32'd0 : cnt_q + 32'd1;

    taps_d = taps_q;
    sum_d  = sum_q;
    if (strobe) begin
      taps_d = {taps_q[NTAPS-2:0], is14_data};
      sum_d  = sum_q + SW'(is14_data) - SW'($signed(taps_q[NTAPS-1]));
    end

    // Copying every cycle holds the value between strobes, since sum only moves on strobes
    out_d = sum_q[SW-1:3];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      taps_q <= '0;
      sum_q  <= '0;
      out_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      taps_q <= taps_d;
      sum_q  <= sum_d;
      out_q  <= out_d;
    end
  end

  assign os14_data = out_q;
endmodule

// File: tb/tb_mv_avg_filter_8.sv
// Directed bench for mv_avg_filter_8: inputs driven and outputs checked on the falling edge.
module tb_mv_avg_filter_8;
  logic               clk;
  logic               rst;
  logic        [31:0] i32_prescaler;
  logic signed [13:0] is14_data;
  logic signed [13:0] os14_data;

  int n_tests = 0;
  int n_fail  = 0;

  mv_avg_filter_8 dut (
    .clk           (clk),
    .rst           (rst),
    .i32_prescaler (i32_prescaler),
    .is14_data     (is14_data),
    .os14_data     (os14_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [13:0] exp);
    n_tests++;
    assert (os14_data === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, os14_data, exp);
    end
  endtask

  // One edge in reset; output must read 0 afterwards, counter restarts at 0.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    check(tag, 14'sd0);
    rst = 1'b0;
  endtask

  // P = 500, data = 1000: strobe k lands on edge 500k, output 125k appears on edge 500k+1.
  task automatic ramp(input int n);
    repeat (500) @(negedge clk);
    check("ramp_pre", 14'sd0);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check($sformatf("ramp_step%0d", k), 14'(125 * k));
      repeat (499) @(negedge clk);
      check($sformatf("ramp_hold%0d", k), 14'(125 * k));
    end
  endtask

  initial begin
    rst           = 1'b1;
    i32_prescaler = 32'd500;
    is14_data     = 14'sd1000;
    repeat (2) @(negedge clk);
    check("reset_state", 14'sd0);

    // Reset after a partial ramp discards history, then a full ramp to 1000
    do_reset("rst_init");
    ramp(5);
    do_reset("rst_midop");
    ramp(8);

    // P = 1 with a negative constant: floor rounding toward -inf
    i32_prescaler = 32'd1;
    is14_data     = -14'sd1001;
    do_reset("rst_p1neg");
    @(negedge clk); check("p1neg_e1", 14'sd0);
    @(negedge clk); check("p1neg_e2", -14'sd126);
    @(negedge clk); check("p1neg_e3", -14'sd251);
    repeat (6) @(negedge clk); check("p1neg_e9", -14'sd1001);
    repeat (3) @(negedge clk); check("p1neg_hold", -14'sd1001);

    // Full-scale extremes: no wrap in the 17-bit sum
    is14_data = 14'sd8191;
    do_reset("rst_ext");
    repeat (8) @(negedge clk);
    is14_data = -14'sd8192;
    @(negedge clk); check("ext_max", 14'sd8191);
    repeat (4) @(negedge clk); check("ext_mid", -14'sd1);
    repeat (4) @(negedge clk); check("ext_min", -14'sd8192);

    // P = 0 acts as P = 1
    i32_prescaler = 32'd0;
    is14_data     = 14'sd800;
    do_reset("rst_p0");
    @(negedge clk); check("p0_e1", 14'sd0);
    @(negedge clk); check("p0_e2", 14'sd100);
    @(negedge clk); check("p0_e3", 14'sd200);

    // Live prescaler change 500 -> 10 with counter at 300
    i32_prescaler = 32'd500;
    do_reset("rst_pchg");
    repeat (300) @(negedge clk); check("pchg_before", 14'sd0);
    i32_prescaler = 32'd10;
    @(negedge clk); check("pchg_e301", 14'sd0);
    @(negedge clk); check("pchg_e302", 14'sd100);
    repeat (9) @(negedge clk); check("pchg_e311", 14'sd100);
    @(negedge clk); check("pchg_e312", 14'sd200);

    // P = 4: junk on non-strobe cycles must not leak into the average
    i32_prescaler = 32'd4;
    do_reset("rst_p4");
    is14_data = 14'sd5000;  @(negedge clk);
    is14_data = -14'sd3000; @(negedge clk);
    is14_data = 14'sd7000;  @(negedge clk);
    is14_data = 14'sd400;   @(negedge clk);
    is14_data = -14'sd8000; @(negedge clk); check("p4_e5", 14'sd50);
    is14_data = 14'sd6000;  @(negedge clk);
    is14_data = -14'sd100;  @(negedge clk);
    is14_data = 14'sd800;   @(negedge clk);
    is14_data = 14'sd4321;  @(negedge clk); check("p4_e9", 14'sd150);
    repeat (2) @(negedge clk); check("p4_hold", 14'sd150);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
